// File: rtl/apb_timer_evt_gen.sv
// APB event generator: picks, syncs, filters and edge-detects event lines for the timer lo/hi halves.
// Optional sticky STATUS register at 0x0C when APB_TIMER_EVT_STATUS_EN is defined.
module apb_timer_evt_gen #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int NUM_EVT        = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR_i,
  input  logic [31:0]               PWDATA_i,
  input  logic                      PWRITE_i,
  input  logic                      PSEL_i,
  input  logic                      PENABLE_i,
  output logic [31:0]               PRDATA_o,
  output logic                      PREADY_o,
  output logic                      PSLVERR_o,
  input  logic [NUM_EVT-1:0]        evt_i,
  output logic                      event_lo_o,
  output logic                      event_hi_o
);

  localparam logic [5:0] A_CFG_LO = 6'h00;
  localparam logic [5:0] A_CFG_HI = 6'h04;
  localparam logic [5:0] A_SW_TRG = 6'h08;
`ifdef APB_TIMER_EVT_STATUS_EN
  localparam logic [5:0] A_STATUS = 6'h0C;
`endif

  logic               wr;
  logic               rd;
  logic [5:0]         addr;
  logic               unused_bits;

  logic [NUM_EVT-1:0] sync1_q;
  logic [NUM_EVT-1:0] sync2_q;
  logic [31:0]        evt_pad;
  logic               new_lvl;

  logic [1:0][4:0]    src_q;
  logic [1:0][1:0]    mode_q;
  logic [1:0][7:0]    filt_q;
  logic [1:0][7:0]    cnt_q;
  logic [1:0]         en_q;
  logic [1:0]         lvl_q;
  logic [1:0]         lvl_d_q;
  logic [1:0]         evt_q;
  logic [1:0]         smp;
  logic [1:0]         hw;
  logic [1:0]         sw;
  logic [1:0]         cfg_wr;

  assign addr      = PADDR_i[5:0];
  assign wr        = PSEL_i & PENABLE_i & PWRITE_i;
  assign rd        = PSEL_i & PENABLE_i & ~PWRITE_i;
  assign PREADY_o  = 1'b1;
  assign PSLVERR_o = 1'b0;

  assign unused_bits = ^{PADDR_i[APB_ADDR_WIDTH-1:6],
                         PWDATA_i[30:24], PWDATA_i[15:10],
                         PWDATA_i[7:5]};

  assign cfg_wr[0] = wr & (addr == A_CFG_LO);
  assign cfg_wr[1] = wr & (addr == A_CFG_HI);
  assign sw        = (wr && addr == A_SW_TRG) ? PWDATA_i[1:0] : 2'b00;

  assign event_lo_o = evt_q[0];
  assign event_hi_o = evt_q[1];

  // Out-of-range sources index into the zero padding.
  always_comb begin
    evt_pad = '0;
    evt_pad[NUM_EVT-1:0] = sync2_q;
  end

  assign new_lvl = evt_pad[PWDATA_i[4:0]];

  always_comb begin
    smp = '0;
    hw  = '0;
    for (int c = 0; c < 2; c++) begin
      smp[c] = evt_pad[src_q[c]];
      hw[c]  = en_q[c] &
               ((lvl_q[c] & ~lvl_d_q[c] & mode_q[c][0]) |
                (~lvl_q[c] & lvl_d_q[c] & mode_q[c][1]));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= evt_i;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q   <= '0;
      mode_q  <= '0;
      filt_q  <= '0;
      en_q    <= '0;
      lvl_q   <= '0;
      lvl_d_q <= '0;
      cnt_q   <= '0;
      evt_q   <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        evt_q[c] <= hw[c] | sw[c];
        if (cfg_wr[c]) begin
          // Reload from the new source so a reconfig never looks like an edge.
          src_q[c]   <= PWDATA_i[4:0];
          mode_q[c]  <= PWDATA_i[9:8];
          filt_q[c]  <= PWDATA_i[23:16];
          en_q[c]    <= PWDATA_i[31];
          lvl_q[c]   <= new_lvl;
          lvl_d_q[c] <= new_lvl;
          cnt_q[c]   <= '0;
        end else begin
          lvl_d_q[c] <= lvl_q[c];
          if (smp[c] == lvl_q[c]) begin
            cnt_q[c] <= '0;
          end else if (cnt_q[c] == filt_q[c]) begin
            lvl_q[c] <= ~lvl_q[c];
            cnt_q[c] <= '0;
          end else begin
            cnt_q[c] <= cnt_q[c] + 8'd1;
          end
        end
      end
    end
  end

`ifdef APB_TIMER_EVT_STATUS_EN
  logic [1:0] stat_q;
  logic [1:0] stat_clr;

  assign stat_clr = (wr && addr == A_STATUS) ? PWDATA_i[1:0] : 2'b00;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_q <= '0;
    end else begin
      stat_q <= (stat_q & ~stat_clr) | evt_q;
    end
  end
`endif

  always_comb begin
    PRDATA_o = '0;
    if (rd) begin
      unique case (1'b1)
        addr == A_CFG_LO:
          PRDATA_o = {en_q[0], 7'b0, filt_q[0], 6'b0,
                      mode_q[0], 3'b0, src_q[0]};
        addr == A_CFG_HI:
          PRDATA_o = {en_q[1], 7'b0, filt_q[1], 6'b0,
                      mode_q[1], 3'b0, src_q[1]};
`ifdef APB_TIMER_EVT_STATUS_EN
        addr == A_STATUS:
          PRDATA_o = {30'b0, stat_q};
`endif
        default: PRDATA_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_timer_evt_gen.sv
// Bench for apb_timer_evt_gen: directed cases plus randomized
// traffic against a run-length reference model.
module tb_apb_timer_evt_gen;

  localparam int NE = 8;
  localparam int N  = 300;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   paddr = '0;
  logic [31:0]   pwdata = '0;
  logic          pwrite = 1'b0;
  logic          psel = 1'b0;
  logic          penable = 1'b0;
  logic [31:0]   prdata;
  logic          pready;
  logic          pslverr;
  logic [NE-1:0] evt = '0;
  logic          ev_lo;
  logic          ev_hi;

  int n_chk = 0;
  int n_fail = 0;

  int lo_cnt, hi_cnt, lo_first, hi_first, hi_second;

  logic [NE-1:0] hist [N];
  logic [1:0]    swh  [N];
  logic [1:0]    obs  [N];
  logic [1:0]    expv [N+8];
  logic [4:0]    r_src  [2];
  logic [1:0]    r_mode [2];
  logic [7:0]    r_f    [2];
  logic          r_en   [2];

  apb_timer_evt_gen #(
    .APB_ADDR_WIDTH(32),
    .NUM_EVT(NE)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .PADDR_i(paddr),
    .PWDATA_i(pwdata),
    .PWRITE_i(pwrite),
    .PSEL_i(psel),
    .PENABLE_i(penable),
    .PRDATA_o(prdata),
    .PREADY_o(pready),
    .PSLVERR_o(pslverr),
    .evt_i(evt),
    .event_lo_o(ev_lo),
    .event_hi_o(ev_hi)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic apb_wr(input logic [5:0] a, input logic [31:0] d);
    paddr = {26'b0, a};
    pwdata = d;
    pwrite = 1'b1;
    psel = 1'b1;
    penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0;
    penable = 1'b0;
    pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [5:0] a, output logic [31:0] d);
    paddr = {26'b0, a};
    pwrite = 1'b0;
    psel = 1'b1;
    penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    #1 d = prdata;
    @(negedge clk);
    psel = 1'b0;
    penable = 1'b0;
  endtask

  // Index k samples outputs before edge E0+k; evt applied at k=0 is caught at E0.
  task automatic watch(input int n, input logic [NE-1:0] mask,
                       input int hi_len);
    lo_cnt = 0;
    hi_cnt = 0;
    lo_first = -1;
    hi_first = -1;
    hi_second = -1;
    for (int k = 0; k < n; k++) begin
      if (ev_lo) begin
        if (lo_cnt == 0) lo_first = k;
        lo_cnt++;
      end
      if (ev_hi) begin
        if (hi_cnt == 0) hi_first = k;
        else if (hi_cnt == 1) hi_second = k;
        hi_cnt++;
      end
      evt = (k < hi_len) ? mask : '0;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] pad;
    logic [NE-1:0] cur;
    logic v, lv;
    int run;

    repeat (3) @(negedge clk);
    check("rst_lo", 32'(ev_lo), 32'd0);
    check("rst_hi", 32'(ev_hi), 32'd0);
    check("rst_prdata", prdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    apb_rd(6'h00, d);
    check("rst_cfg_lo", d, 32'd0);
    apb_rd(6'h04, d);
    check("rst_cfg_hi", d, 32'd0);

    // lo: SRC3 rising F0
    apb_wr(6'h00, 32'h8000_0103);
    watch(12, 8'h08, 12);
    check("rise_lo_cnt", 32'(lo_cnt), 32'd1);
    check("rise_lo_at", 32'(lo_first), 32'd4);
    check("rise_hi_cnt", 32'(hi_cnt), 32'd0);
    watch(8, 8'h00, 0);
    check("fall_ignored", 32'(lo_cnt), 32'd0);

    // hi: SRC1 both F4
    apb_wr(6'h04, 32'h8004_0301);
    watch(20, 8'h02, 4);
    check("glitch_hi", 32'(hi_cnt), 32'd0);
    watch(30, 8'h02, 10);
    check("pulse_hi_cnt", 32'(hi_cnt), 32'd2);
    check("pulse_hi_rise", 32'(hi_first), 32'd8);
    check("pulse_hi_fall", 32'(hi_second), 32'd18);

    apb_wr(6'h08, 32'h3);
    check("swt_lo", 32'(ev_lo), 32'd1);
    check("swt_hi", 32'(ev_hi), 32'd1);
    @(negedge clk);
    check("swt_lo_end", 32'(ev_lo), 32'd0);
    check("swt_hi_end", 32'(ev_hi), 32'd0);

    fork
      watch(12, 8'h08, 12);
      begin
        repeat (2) @(negedge clk);
        apb_wr(6'h08, 32'h1);
      end
    join
    check("coinc_cnt", 32'(lo_cnt), 32'd1);
    check("coinc_at", 32'(lo_first), 32'd4);
    watch(6, 8'h00, 0);

    paddr = 32'h8;
    pwdata = 32'h1;
    pwrite = 1'b1;
    psel = 1'b1;
    penable = 1'b1;
    @(negedge clk);
    check("b2b_1", 32'(ev_lo), 32'd1);
    @(negedge clk);
    psel = 1'b0;
    penable = 1'b0;
    pwrite = 1'b0;
    check("b2b_2", 32'(ev_lo), 32'd1);
    @(negedge clk);
    check("b2b_end", 32'(ev_lo), 32'd0);

    watch(5, 8'h04, 5);
    apb_wr(6'h00, 32'h8000_0102);
    watch(15, 8'h04, 15);
    check("held_high", 32'(lo_cnt), 32'd0);
    watch(10, 8'h00, 0);
    check("held_fall", 32'(lo_cnt), 32'd0);

    apb_wr(6'h00, 32'hFFFF_FFFF);
    apb_rd(6'h00, d);
    check("cfg_lo_mask", d, 32'h80FF_031F);
    apb_rd(6'h04, d);
    check("cfg_hi_rb", d, 32'h8004_0301);
    watch(20, 8'hFF, 10);
    check("src31_lo", 32'(lo_cnt), 32'd0);
    watch(20, 8'h00, 0);
    apb_rd(6'h10, d);
    check("rd_0x10", d, 32'd0);
    apb_rd(6'h08, d);
    check("rd_swt", d, 32'd0);
`ifndef APB_TIMER_EVT_STATUS_EN
    apb_rd(6'h0C, d);
    check("rd_0x0c", d, 32'd0);
`endif

    for (int r = 0; r < 4; r++) begin
      evt = '0;
      repeat (4) @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        r_src[c]  = 5'($urandom_range(0, 9));
        r_mode[c] = 2'($urandom_range(0, 3));
        r_f[c]    = 8'($urandom_range(0, 6));
        r_en[c]   = ($urandom_range(0, 3) != 0);
        apb_wr(c == 0 ? 6'h00 : 6'h04,
               {r_en[c], 7'b0, r_f[c], 6'b0, r_mode[c], 3'b0, r_src[c]});
      end
      cur = '0;
      for (int k = 0; k < N; k++) begin
        if (k < N - 20) begin
          for (int b = 0; b < NE; b++)
            if ($urandom_range(0, 4) == 0) cur[b] = ~cur[b];
          swh[k] = ($urandom_range(0, 11) == 0) ?
                   2'($urandom_range(1, 3)) : 2'b00;
        end else begin
          cur = '0;
          swh[k] = 2'b00;
        end
        hist[k] = cur;
      end
      for (int k = 0; k < N; k++) begin
        obs[k] = {ev_hi, ev_lo};
        evt = hist[k];
        if (swh[k] != 2'b00) begin
          paddr = 32'h8;
          pwdata = {30'b0, swh[k]};
          pwrite = 1'b1;
          psel = 1'b1;
          penable = 1'b1;
        end else begin
          psel = 1'b0;
          penable = 1'b0;
          pwrite = 1'b0;
        end
        @(negedge clk);
      end
      psel = 1'b0;
      penable = 1'b0;
      pwrite = 1'b0;
      for (int k = 0; k < N + 8; k++) expv[k] = 2'b00;
      for (int c = 0; c < 2; c++) begin
        lv = 1'b0;
        run = 0;
        for (int k = 0; k < N; k++) begin
          pad = '0;
          pad[NE-1:0] = hist[k];
          v = pad[r_src[c]];
          if (swh[k][c]) expv[k+1][c] = 1'b1;
          if (v == lv) begin
            run = 0;
          end else begin
            run++;
            if (run == int'(r_f[c]) + 1) begin
              lv = v;
              run = 0;
              if (r_en[c] && ((v && r_mode[c][0]) || (!v && r_mode[c][1])))
                expv[k+4][c] = 1'b1;
            end
          end
        end
      end
      for (int k = 0; k < N; k++) begin
        if (obs[k] !== expv[k])
          check($sformatf("rnd%0d_k%0d", r, k), 32'(obs[k]), 32'(expv[k]));
        else
          check("rnd", 32'(obs[k]), 32'(expv[k]));
      end
    end

`ifdef APB_TIMER_EVT_STATUS_EN
    apb_wr(6'h0C, 32'h3);
    apb_rd(6'h0C, d);
    check("stat_clr0", d, 32'd0);
    apb_wr(6'h08, 32'h1);
    apb_rd(6'h0C, d);
    check("stat_set", d, 32'h1);
    apb_wr(6'h0C, 32'h1);
    apb_rd(6'h0C, d);
    check("stat_w1c", d, 32'h0);
    paddr = 32'h8;
    pwdata = 32'h1;
    pwrite = 1'b1;
    psel = 1'b1;
    penable = 1'b1;
    @(negedge clk);
    paddr = 32'hC;
    @(negedge clk);
    psel = 1'b0;
    penable = 1'b0;
    pwrite = 1'b0;
    apb_rd(6'h0C, d);
    check("stat_set_wins", d, 32'h1);
`endif

    apb_wr(6'h00, 32'h8008_0301);
    watch(5, 8'h02, 5);
    apb_wr(6'h08, 32'h1);
    check("pre_rst_lo", 32'(ev_lo), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_lo", 32'(ev_lo), 32'd0);
    check("async_rst_hi", 32'(ev_hi), 32'd0);
    paddr = 32'h0;
    pwrite = 1'b0;
    psel = 1'b1;
    penable = 1'b1;
    #1 check("rst_rd_cfg", prdata, 32'd0);
    psel = 1'b0;
    penable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apb_wr(6'h00, 32'h8008_0301);
    watch(30, 8'h02, 30);
    check("post_rst_lo", 32'(lo_cnt), 32'd0);
    check("post_rst_hi", 32'(hi_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
